// File: rtl/seq_pattern_counter.sv
// seq_pattern_counter
//   Programmable serial pattern detector. It matches a loadable, maskable
//   PAT_LEN-bit pattern against the most recent ena-qualified samples of
//   sig_to_test. Matches are counted in a DIGITS-digit BCD counter, and that
//   counter is shown on an active-low 7-segment bank.
//
// Ports
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset; overrides pat_load and ena
//   ena          sample enable; sig_to_test is consumed only when high
//   sig_to_test  serial bit under test
//   overlap      1 = overlapping matches, 0 = flush fill after each match
//   pat_load     one-cycle strobe loading pat_value / pat_mask
//   pat_value    new pattern, MSB = oldest bit
//   pat_mask     care mask, 1 = compare, 0 = don't care (all zero = disabled)
//   z            registered one-cycle match pulse
//   count_bcd    BCD match count, digit 0 in [3:0]
//   sat          sticky flag, set once the count reaches all-9s when WRAP=0
//   seg          active-low segments {g..a} per digit, digit 0 in [6:0]
module seq_pattern_counter #(
  parameter int                 PAT_LEN = 4,
  parameter int                 DIGITS  = 2,
  parameter logic [PAT_LEN-1:0] PAT_RST = PAT_LEN'(4'b0101),
  parameter bit                 WRAP    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  sig_to_test,
  input  logic                  overlap,
  input  logic                  pat_load,
  input  logic [PAT_LEN-1:0]    pat_value,
  input  logic [PAT_LEN-1:0]    pat_mask,
  output logic                  z,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  sat,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int             FW        = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]  FILL_FULL = FW'(PAT_LEN);

  // Active-low {g..a} decode. Non-BCD codes are shown as a distinct glyph.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = 7'b1000000;
      4'd1:    seg_encode = 7'b1111001;
      4'd2:    seg_encode = 7'b0100100;
      4'd3:    seg_encode = 7'b0110000;
      4'd4:    seg_encode = 7'b0011001;
      4'd5:    seg_encode = 7'b0010010;
      4'd6:    seg_encode = 7'b0000010;
      4'd7:    seg_encode = 7'b1111000;
      4'd8:    seg_encode = 7'b0000000;
      4'd9:    seg_encode = 7'b0011000;
      default: seg_encode = 7'b0000111;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [PAT_LEN-1:0]  hist_reg,  hist_next;
  logic [FW-1:0]       fill_reg,  fill_next;
  logic [PAT_LEN-1:0]  pat_reg,   pat_next;
  logic [PAT_LEN-1:0]  mask_reg,  mask_next;
  logic                match_reg, match_next;   // match seen at the sample edge
  logic                z_reg;
  logic [4*DIGITS-1:0] count_reg, count_next;
  logic                sat_reg,   sat_next;
  logic [7*DIGITS-1:0] seg_reg,   seg_next;

  // ---------------------------------------------------------------------
  // Front end: history shift, fill tracking and match detection.
  // The match test uses the history that includes the current bit, so
  // the match is known at the sample edge. It is then registered once
  // more to form z, which puts z one cycle after the completing sample.
  // ---------------------------------------------------------------------
  logic [PAT_LEN-1:0] hist_shift;
  logic [FW-1:0]      fill_inc;

  assign hist_shift = {hist_reg[PAT_LEN-2:0], sig_to_test};
  assign fill_inc   = (fill_reg == FILL_FULL) ? FILL_FULL : fill_reg + FW'(1);

  always_comb begin
    hist_next  = hist_reg;
    fill_next  = fill_reg;
    pat_next   = pat_reg;
    mask_next  = mask_reg;
    match_next = 1'b0;
    if (pat_load) begin
      // A load discards any sample presented in the same cycle.
      pat_next  = pat_value;
      mask_next = pat_mask;
      hist_next = '0;
      fill_next = '0;
    end else if (ena) begin
      hist_next = hist_shift;
      fill_next = fill_inc;
      if ((fill_inc == FILL_FULL) && (mask_reg != '0) &&
          (((hist_shift ^ pat_reg) & mask_reg) == '0)) begin
        match_next = 1'b1;
        // Non-overlapping mode: require PAT_LEN fresh bits for the next match.
        if (!overlap) fill_next = '0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // BCD ripple increment. carry[gi] means every digit below gi is 9.
  // ---------------------------------------------------------------------
  logic [DIGITS:0]     carry;
  logic [DIGITS-1:0]   inc_nine;
  logic [4*DIGITS-1:0] count_inc;
  logic                at_max;

  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] d;
      logic       is_nine;
      assign d       = count_reg[4*gi +: 4];
      assign is_nine = (d == 4'd9);
      assign count_inc[4*gi +: 4] = carry[gi] ? (is_nine ? 4'd0 : d + 4'd1) : d;
      assign carry[gi+1]  = carry[gi] & is_nine;
      assign inc_nine[gi] = (count_inc[4*gi +: 4] == 4'd9);
      assign seg_next[7*gi +: 7] = seg_encode(d);
    end
  endgenerate

  assign at_max = carry[DIGITS];

  always_comb begin
    count_next = count_reg;
    sat_next   = sat_reg;
    if (match_reg) begin
      if (!(at_max && !WRAP)) count_next = count_inc;
      // The flag goes up as soon as the counter lands on all-9s.
      if (!WRAP && (&inc_nine)) sat_next = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_reg  <= '0;
      fill_reg  <= '0;
      pat_reg   <= PAT_RST;
      mask_reg  <= '1;
      match_reg <= 1'b0;
      z_reg     <= 1'b0;
      count_reg <= '0;
      sat_reg   <= 1'b0;
      seg_reg   <= {DIGITS{7'b1000000}};
    end else begin
      hist_reg  <= hist_next;
      fill_reg  <= fill_next;
      pat_reg   <= pat_next;
      mask_reg  <= mask_next;
      match_reg <= match_next;
      z_reg     <= match_reg;
      count_reg <= count_next;
      sat_reg   <= sat_next;
      seg_reg   <= seg_next;
    end
  end

  assign z         = z_reg;
  assign count_bcd = count_reg;
  assign sat       = sat_reg;
  assign seg       = seg_reg;

endmodule

// File: tb/tb_seq_pattern_counter.sv
// Directed bench for seq_pattern_counter. dut0 runs in saturate mode and
// dut1 in wrap mode. Both share their inputs, and most checks look at dut0.
module tb_seq_pattern_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0;
  logic       sig = 1'b0;
  logic       overlap = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_value = 4'b0000;
  logic [3:0] pat_mask = 4'b0000;

  logic        z0, sat0, z1, sat1;
  logic [7:0]  count0, count1;
  logic [13:0] seg0, seg1;

  int vectors = 0;
  int miscompares = 0;
  int zcnt = 0;
  int base = 0;

  localparam logic [13:0] SEG_00 = {7'b1000000, 7'b1000000};
  localparam logic [13:0] SEG_01 = {7'b1000000, 7'b1111001};
  localparam logic [13:0] SEG_99 = {7'b0011000, 7'b0011000};

  always #5 clk = ~clk;

  seq_pattern_counter #(.PAT_LEN(4), .DIGITS(2), .PAT_RST(4'b0101), .WRAP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .ena(ena), .sig_to_test(sig), .overlap(overlap),
    .pat_load(pat_load), .pat_value(pat_value), .pat_mask(pat_mask),
    .z(z0), .count_bcd(count0), .sat(sat0), .seg(seg0));

  seq_pattern_counter #(.PAT_LEN(4), .DIGITS(2), .PAT_RST(4'b0101), .WRAP(1'b1)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .sig_to_test(sig), .overlap(overlap),
    .pat_load(pat_load), .pat_value(pat_value), .pat_mask(pat_mask),
    .z(z1), .count_bcd(count1), .sat(sat1), .seg(seg1));

  // Count z pulses of dut0, sampled mid-cycle.
  always @(negedge clk) if (z0 === 1'b1) zcnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    sig = b;
    ena = 1'b1;
    tick();
    ena = 1'b0;
  endtask

  task automatic idle(input int n);
    ena = 1'b0;
    sig = 1'b1;
    repeat (n) tick();
  endtask

  task automatic load(input logic [3:0] v, input logic [3:0] m);
    pat_value = v;
    pat_mask = m;
    pat_load = 1'b1;
    tick();
    pat_load = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++; if (z0 !== 1'b0) begin miscompares++; $display("FAIL reset_z: got %b want 0", z0); end
    vectors++; if (count0 !== 8'h00) begin miscompares++; $display("FAIL reset_count: got %h want 00", count0); end
    vectors++; if (sat0 !== 1'b0) begin miscompares++; $display("FAIL reset_sat: got %b want 0", sat0); end
    vectors++; if (seg0 !== SEG_00) begin miscompares++; $display("FAIL reset_seg: got %b want %b", seg0, SEG_00); end
    $display("test_reset: done");
  endtask

  task automatic test_default();
    send(0); send(1); send(0); send(1);
    vectors++; if (z0 !== 1'b0) begin miscompares++; $display("FAIL default_z_early: got %b want 0", z0); end
    tick();
    vectors++; if (z0 !== 1'b1) begin miscompares++; $display("FAIL default_z: got %b want 1", z0); end
    vectors++; if (count0 !== 8'h01) begin miscompares++; $display("FAIL default_count: got %h want 01", count0); end
    tick();
    vectors++; if (z0 !== 1'b0) begin miscompares++; $display("FAIL default_z_pulse: got %b want 0", z0); end
    vectors++; if (seg0 !== SEG_01) begin miscompares++; $display("FAIL default_seg: got %b want %b", seg0, SEG_01); end
    $display("test_default: done");
  endtask

  task automatic test_overlap();
    do_reset();
    overlap = 1'b1;
    base = zcnt;
    send(0); send(1); send(0); send(1); send(0); send(1);
    tick(); tick();
    vectors++; if (zcnt - base !== 2) begin miscompares++; $display("FAIL overlap1_pulses: got %0d want 2", zcnt - base); end
    vectors++; if (count0 !== 8'h02) begin miscompares++; $display("FAIL overlap1_count: got %h want 02", count0); end
    do_reset();
    overlap = 1'b0;
    base = zcnt;
    send(0); send(1); send(0); send(1); send(0); send(1);
    tick(); tick();
    vectors++; if (zcnt - base !== 1) begin miscompares++; $display("FAIL overlap0_pulses: got %0d want 1", zcnt - base); end
    vectors++; if (count0 !== 8'h01) begin miscompares++; $display("FAIL overlap0_count: got %h want 01", count0); end
    $display("test_overlap: done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    overlap = 1'b1;
    load(4'b1111, 4'b1111);
    send(1); send(1); send(1); send(1);
    vectors++; if (z0 !== 1'b0) begin miscompares++; $display("FAIL b2b_z0: got %b want 0", z0); end
    send(1);
    vectors++; if (z0 !== 1'b1) begin miscompares++; $display("FAIL b2b_z1: got %b want 1", z0); end
    send(1);
    vectors++; if (z0 !== 1'b1) begin miscompares++; $display("FAIL b2b_z2: got %b want 1", z0); end
    tick();
    vectors++; if (z0 !== 1'b1) begin miscompares++; $display("FAIL b2b_z3: got %b want 1", z0); end
    tick();
    vectors++; if (z0 !== 1'b0) begin miscompares++; $display("FAIL b2b_z_end: got %b want 0", z0); end
    vectors++; if (count0 !== 8'h03) begin miscompares++; $display("FAIL b2b_count: got %h want 03", count0); end
    $display("test_back_to_back: done");
  endtask

  task automatic test_mask();
    do_reset();
    overlap = 1'b1;
    load(4'b0101, 4'b1011);
    send(0); send(0); send(0); send(1);
    tick();
    vectors++; if (z0 !== 1'b1) begin miscompares++; $display("FAIL mask_z: got %b want 1", z0); end
    vectors++; if (count0 !== 8'h01) begin miscompares++; $display("FAIL mask_count: got %h want 01", count0); end
    load(4'b0101, 4'b0000);
    base = zcnt;
    send(1); send(0); send(1); send(1); send(0); send(1); send(0); send(1);
    tick(); tick();
    vectors++; if (zcnt - base !== 0) begin miscompares++; $display("FAIL mask_zero_pulses: got %0d want 0", zcnt - base); end
    vectors++; if (count0 !== 8'h01) begin miscompares++; $display("FAIL mask_zero_count: got %h want 01", count0); end
    $display("test_mask: done");
  endtask

  task automatic test_collision();
    do_reset();
    overlap = 1'b1;
    base = zcnt;
    // Without the load, this 1 would complete 0101.
    send(0); send(1); send(0);
    pat_value = 4'b0101; pat_mask = 4'b1111; pat_load = 1'b1; ena = 1'b1; sig = 1'b1;
    tick();
    pat_load = 1'b0; ena = 1'b0;
    tick(); tick();
    vectors++; if (zcnt - base !== 0) begin miscompares++; $display("FAIL collide_match: got %0d pulses want 0", zcnt - base); end
    // If this 0 were kept, 1,0,1 would complete 0101.
    pat_load = 1'b1; ena = 1'b1; sig = 1'b0;
    tick();
    pat_load = 1'b0; ena = 1'b0;
    send(1); send(0); send(1);
    tick(); tick();
    vectors++; if (zcnt - base !== 0) begin miscompares++; $display("FAIL collide_fill: got %0d pulses want 0", zcnt - base); end
    load(4'b0101, 4'b1111);
    send(0); idle(2); send(1); idle(1); send(0); idle(3); send(1);
    vectors++; if (z0 !== 1'b0) begin miscompares++; $display("FAIL gap_z_early: got %b want 0", z0); end
    tick();
    vectors++; if (z0 !== 1'b1) begin miscompares++; $display("FAIL gap_z: got %b want 1", z0); end
    tick();
    vectors++; if (zcnt - base !== 1) begin miscompares++; $display("FAIL gap_pulses: got %0d want 1", zcnt - base); end
    vectors++; if (count0 !== 8'h01) begin miscompares++; $display("FAIL gap_count: got %h want 01", count0); end
    $display("test_collision: done");
  endtask

  task automatic test_saturate();
    do_reset();
    overlap = 1'b1;
    load(4'b1111, 4'b1111);
    repeat (102) send(1);   // matches on bits 4..102 = 99
    tick();
    vectors++; if (count0 !== 8'h99) begin miscompares++; $display("FAIL sat_count99: got %h want 99", count0); end
    vectors++; if (count1 !== 8'h99) begin miscompares++; $display("FAIL wrap_count99: got %h want 99", count1); end
    vectors++; if (sat1 !== 1'b0) begin miscompares++; $display("FAIL wrap_sat99: got %b want 0", sat1); end
    send(1);                // 100th match
    tick();
    vectors++; if (count0 !== 8'h99) begin miscompares++; $display("FAIL sat_count: got %h want 99", count0); end
    vectors++; if (sat0 !== 1'b1) begin miscompares++; $display("FAIL sat_flag: got %b want 1", sat0); end
    vectors++; if (count1 !== 8'h00) begin miscompares++; $display("FAIL wrap_count: got %h want 00", count1); end
    vectors++; if (sat1 !== 1'b0) begin miscompares++; $display("FAIL wrap_sat: got %b want 0", sat1); end
    tick();
    vectors++; if (seg0 !== SEG_99) begin miscompares++; $display("FAIL sat_seg: got %b want %b", seg0, SEG_99); end
    vectors++; if (seg1 !== SEG_00) begin miscompares++; $display("FAIL wrap_seg: got %b want %b", seg1, SEG_00); end
    $display("test_saturate: done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    overlap = 1'b1;
    load(4'b1111, 4'b1111);
    repeat (40) send(1);    // 37 matches
    tick();
    vectors++; if (count0 !== 8'h37) begin miscompares++; $display("FAIL mid_count37: got %h want 37", count0); end
    load(4'b0111, 4'b1111);
    send(0); send(1); send(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (z0 !== 1'b0) begin miscompares++; $display("FAIL mid_z: got %b want 0", z0); end
    vectors++; if (count0 !== 8'h00) begin miscompares++; $display("FAIL mid_count: got %h want 00", count0); end
    vectors++; if (sat0 !== 1'b0) begin miscompares++; $display("FAIL mid_sat: got %b want 0", sat0); end
    vectors++; if (seg0 !== SEG_00) begin miscompares++; $display("FAIL mid_seg: got %b want %b", seg0, SEG_00); end
    base = zcnt;
    send(1);
    tick(); tick();
    vectors++; if (zcnt - base !== 0) begin miscompares++; $display("FAIL mid_no_match: got %0d pulses want 0", zcnt - base); end
    vectors++; if (count0 !== 8'h00) begin miscompares++; $display("FAIL mid_count_after: got %h want 00", count0); end
    $display("test_reset_mid: done");
  endtask

  initial begin
    test_reset();
    test_default();
    test_overlap();
    test_back_to_back();
    test_mask();
    test_collision();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
